// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: streams NUM_BYTES register bytes (address = position) MSB first
// under one ss-low window, fetching each byte from a synchronous RAM one byte ahead.
module spi_frame_master #(
    parameter int NUM_BYTES   = 25,
    parameter int ADDR_W      = 5,
    parameter int HALF_PERIOD = 4,
    parameter int SS_SETUP    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              ss,
    output logic              sclk,
    output logic              mosi
);

    localparam int CNT_MAX = (HALF_PERIOD > SS_SETUP) ? HALF_PERIOD : SS_SETUP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0]  HP_LAST   = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]  SS_LAST   = CNT_W'(SS_SETUP - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [2:0]          bit_cnt_reg, bit_cnt_next;
    logic [BYTE_W-1:0]   byte_cnt_reg, byte_cnt_next;

    logic                ss_reg, sclk_reg, busy_reg, done_reg;
    logic                rd_en_reg, rd_pend_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [7:0]          shift_reg, pf_buf_reg;

    logic                accept, fall_edge, prefetch;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        accept        = 1'b0;
        fall_edge     = 1'b0;
        prefetch      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept        = 1'b1;
                    state_next    = FETCH;
                    cnt_next      = '0;
                    bit_cnt_next  = '0;
                    byte_cnt_next = '0;
                end
            end
            FETCH: begin
                state_next = SETUP;
                cnt_next   = '0;
            end
            SETUP: begin
                if (cnt_reg == SS_LAST) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_reg == HP_LAST) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_reg == HP_LAST) begin
                    fall_edge    = 1'b1;
                    cnt_next     = '0;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    // Next byte's read goes out as bit 1 begins, leaving 6+ bit times for the RAM.
                    prefetch     = (bit_cnt_reg == 3'd0) && (byte_cnt_reg != BYTE_LAST);
                    if (bit_cnt_reg == 3'd7 && byte_cnt_reg == BYTE_LAST) begin
                        state_next    = HOLD;
                        byte_cnt_next = '0;
                    end else begin
                        state_next = LOW;
                        if (bit_cnt_reg == 3'd7) begin
                            byte_cnt_next = byte_cnt_reg + BYTE_W'(1);
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_reg == SS_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_reg == SS_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pin registers are loaded from the next state so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            ss_reg       <= 1'b1;
            sclk_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_pend_reg  <= 1'b0;
            rd_addr_reg  <= '0;
            shift_reg    <= '0;
            pf_buf_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            ss_reg       <= (state_next == IDLE) || (state_next == GAP);
            sclk_reg     <= (state_next == HIGH);
            busy_reg     <= (state_next != IDLE);
            done_reg     <= (state_reg == HOLD) && (state_next == GAP);
            rd_en_reg    <= accept || prefetch;
            rd_pend_reg  <= rd_en_reg;

            if (accept) begin
                rd_addr_reg <= '0;
            end else if (prefetch) begin
                rd_addr_reg <= ADDR_W'(byte_cnt_reg + BYTE_W'(1));
            end

            // Byte 0 goes straight to the shifter during SETUP; later bytes wait in the buffer.
            if (rd_pend_reg && state_reg == SETUP) begin
                shift_reg <= rd_data;
            end else if (fall_edge) begin
                if (bit_cnt_reg == 3'd7) begin
                    if (byte_cnt_reg != BYTE_LAST) begin
                        shift_reg <= pf_buf_reg;
                    end
                end else begin
                    shift_reg <= {shift_reg[6:0], 1'b0};
                end
            end

            if (rd_pend_reg && state_reg != SETUP) begin
                pf_buf_reg <= rd_data;
            end
        end
    end

    assign ss      = ss_reg;
    assign sclk    = sclk_reg;
    assign mosi    = shift_reg[7];
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: stimulus pushes expected bytes/addresses,
// a negedge monitor acts as the SPI receiver and pops/compares as the DUT produces them.
module tb_spi_frame_master;

    localparam int NB     = 25;
    localparam int ADDR_W = 5;
    localparam int HP     = 4;
    localparam int SSU    = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy, done, rd_en, ss, sclk, mosi;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    logic [7:0] ram [32];
    int         exp_byte[$];
    int         exp_addr[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int n_ss_fall = 0;
    int t_ss_rise = 0;
    int last_gap = 0;
    int sclk_ss_err = 0;
    bit abort = 0;

    spi_frame_master #(
        .NUM_BYTES  (NB),
        .ADDR_W     (ADDR_W),
        .HALF_PERIOD(HP),
        .SS_SETUP   (SSU)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .ss     (ss),
        .sclk   (sclk),
        .mosi   (mosi)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Synchronous RAM: data valid one clk after rd_en.
    initial begin
        rd_data = 8'h00;
        forever begin
            @(posedge clk);
            if (rd_en) rd_data <= ram[rd_addr];
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Receiver / monitor
    initial begin
        logic       ss_q, sclk_q, mosi_q, busy_q;
        int         t_ss_fall, t_last_rise, t_last_fall, t_mosi, rises, nbits, e;
        bit         first_rise;
        logic [7:0] acc;
        ss_q = 1; sclk_q = 0; mosi_q = 0; busy_q = 0;
        t_ss_fall = 0; t_last_rise = 0; t_last_fall = 0; t_mosi = 0;
        rises = 0; nbits = 0; first_rise = 0; acc = 8'h00;
        forever begin
            @(negedge clk);
            if (mosi !== mosi_q) t_mosi = cyc;
            if (ss_q && !ss) begin
                n_ss_fall++;
                last_gap   = cyc - t_ss_rise;
                t_ss_fall  = cyc;
                first_rise = 1;
                rises      = 0;
                nbits      = 0;
            end
            if (!sclk_q && sclk) begin
                if (first_rise) check("first_rise_after_ss_fall", cyc - t_ss_fall, 1 + SSU + HP);
                else            check("sclk_period", cyc - t_last_rise, 2 * HP);
                check("mosi_setup_before_rise", 32'((cyc - t_mosi) >= HP), 1);
                first_rise  = 0;
                t_last_rise = cyc;
                rises++;
                acc = {acc[6:0], mosi};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_byte.size() == 0) begin
                        check("unexpected_byte_no_expectation", acc, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_byte.pop_front();
                        check("mosi_byte", acc, e);
                    end
                end
            end
            if (sclk_q && !sclk) t_last_fall = cyc;
            if (!ss_q && ss) begin
                if (!abort) begin
                    check("ss_rise_after_last_fall", cyc - t_last_fall, SSU);
                    check("done_with_ss_rise", done, 1);
                    check("rises_per_frame", rises, 8 * NB);
                end
                t_ss_rise = cyc;
            end
            if (busy_q && !busy && !abort) check("busy_fall_after_ss_rise", cyc - t_ss_rise, SSU);
            if (rd_en) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_rd_en", rd_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_addr.pop_front();
                    check("rd_addr", rd_addr, e);
                end
            end
            if (done) done_cnt++;
            if (ss && sclk) sclk_ss_err++;
            if (ss) nbits = 0;
            ss_q = ss; sclk_q = sclk; mosi_q = mosi; busy_q = busy;
        end
    end

    task automatic push_frame();
        for (int k = 0; k < NB; k++) begin
            exp_byte.push_back(int'(ram[k]));
            exp_addr.push_back(k);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || ss !== 1'b1) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 4000), 1);
    endtask

    task automatic wait_addr(input int addr, input string name);
        int n;
        n = 0;
        while (!(rd_en === 1'b1 && int'(rd_addr) == addr) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 4000), 1);
    endtask

    initial begin
        int d0, nf, n;
        rst_n = 1;
        start = 0;
        for (int k = 0; k < 32; k++) ram[k] = 8'(k + 8'h30);
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_ss", ss, 1);
        check("reset_sclk", sclk, 0);
        check("reset_mosi", mosi, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Frame 1: ascending pattern 0x30..0x48
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_idle("frame1_completes");
        check("frame1_done_pulses", done_cnt - d0, 1);
        $display("frame 1 (0x30..0x48) finished, done pulses %0d", done_cnt - d0);

        // Frame 2: first byte 0xA5
        ram[0] = 8'hA5;
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_idle("frame2_completes");
        check("frame2_done_pulses", done_cnt - d0, 1);
        $display("frame 2 (byte0=0xA5) finished, done pulses %0d", done_cnt - d0);
        ram[0] = 8'h30;

        // Frame 3: start pulsed during byte 10 must be ignored
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_addr(11, "frame3_reach_byte10");
        pulse_start();
        wait_idle("frame3_completes");
        repeat (60) @(negedge clk);
        check("frame3_no_second_frame_busy", busy, 0);
        check("frame3_no_second_frame_ss", ss, 1);
        check("frame3_done_pulses", done_cnt - d0, 1);
        $display("frame 3 (start during byte 10) finished, done pulses %0d", done_cnt - d0);

        // Frame 4: asynchronous reset in byte 5, bit 1 HIGH phase
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_addr(6, "frame4_reach_byte5");
        n = 0;
        while (sclk !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("frame4_reach_high_phase", 32'(n < 100), 1);
        #2;
        abort = 1;
        rst_n = 0;
        #1;
        check("abort_ss_async", ss, 1);
        check("abort_sclk_async", sclk, 0);
        check("abort_busy_async", busy, 0);
        check("abort_rd_addr_async", rd_addr, 0);
        exp_byte.delete();
        exp_addr.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        abort = 0;
        check("frame4_no_done", done_cnt - d0, 0);
        $display("frame 4 aborted by reset during byte 5");

        // Frame 5: full frame after reset starts again at address 0
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_idle("frame5_completes");
        check("frame5_done_pulses", done_cnt - d0, 1);
        $display("frame 5 (after reset) finished, done pulses %0d", done_cnt - d0);

        // Frames 6+7: start held high, back to back
        d0 = done_cnt;
        push_frame();
        push_frame();
        nf = n_ss_fall;
        @(negedge clk);
        start = 1;
        n = 0;
        while (n_ss_fall < nf + 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        start = 0;
        check("b2b_second_frame_started", 32'(n < 5000), 1);
        check("b2b_ss_high_gap", last_gap, SSU + 1);
        wait_idle("b2b_completes");
        check("b2b_done_pulses", done_cnt - d0, 2);
        $display("frames 6-7 (back to back) finished, gap %0d, done pulses %0d", last_gap, done_cnt - d0);

        repeat (5) @(negedge clk);
        check("all_expected_bytes_seen", exp_byte.size(), 0);
        check("all_expected_reads_seen", exp_addr.size(), 0);
        check("sclk_low_while_ss_high", sclk_ss_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
